nes_clk_rst_gen: RTL and testbench



---
 rtl/nes_pkg.sv | 33 +++
 rtl/nes_clk_rst_gen_if.sv | 28 ++
 rtl/nes_ce_div.sv | 37 +++
 rtl/nes_clk_rst_gen.sv | 130 +++++++++++++
 tb/tb_nes_clk_rst_gen.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/nes_pkg.sv
// Shared types and default divisors for the NES clock/reset generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package nes_pkg;

    typedef enum logic [1:0] {
        HOLD   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2,
        STEP   = 2'd3
    } clk_state_t;

    typedef enum logic {
        NTSC = 1'b0,
        PAL  = 1'b1
    } mode_t;

    localparam int DEF_NTSC_CPU_DIV = 12;
    localparam int DEF_NTSC_PPU_DIV = 4;
    localparam int DEF_PAL_CPU_DIV  = 16;
    localparam int DEF_PAL_PPU_DIV  = 5;

    // Largest of the four divisors; sizes the shared phase counters.
    function automatic int max_div(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/nes_clk_rst_gen_if.sv
// Control/status bundle between the clock/reset generator and its consumers.
// Latency: n/a (wires only).
// Backpressure: none; enables are free-running pulses.
interface nes_clk_rst_gen_if #(
    parameter int CYC_W = 32
);
    logic             pal_mode;
    logic             halt;
    logic             step;
    logic             cpu_ce;
    logic             ppu_ce;
    logic             cpu_rst;
    logic             ppu_rst;
    logic             halted;
    logic [CYC_W-1:0] cpu_cycles;

    // Controller side: drives mode/debug requests, observes enables and resets.
    modport master (
        output pal_mode, halt, step,
        input  cpu_ce, ppu_ce, cpu_rst, ppu_rst, halted, cpu_cycles
    );

    // Generator side.
    modport slave (
        input  pal_mode, halt, step,
        output cpu_ce, ppu_ce, cpu_rst, ppu_rst, halted, cpu_cycles
    );
endinterface

// File: rtl/nes_ce_div.sv
// Modulo counter 0..last_i with enable and clear; tc_o pulses on the terminal count.
// Latency: tc_o is a combinational decode of the registered count.
// Backpressure: none; en_i low simply freezes the count.
module nes_ce_div #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic         clr_i,
    input  logic [W-1:0] last_i,   // divisor minus one
    output logic         tc_o
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tc_o = en_i && (cnt_q == last_i);

    // Next count: clear dominates, otherwise advance and wrap at the terminal value.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tc_o ? '0 : cnt_q + W'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/nes_clk_rst_gen.sv
// CPU/PPU clock enables from sys_clock, sequenced domain resets, debug halt/single-step.
// Latency: all outputs decode registered state; halt/step act on the next CPU boundary/cycle.
// Backpressure: none; halt freezes both enables only at a CPU cycle boundary.
module nes_clk_rst_gen
    import nes_pkg::*;
#(
    parameter int NTSC_CPU_DIV = DEF_NTSC_CPU_DIV,
    parameter int NTSC_PPU_DIV = DEF_NTSC_PPU_DIV,
    parameter int PAL_CPU_DIV  = DEF_PAL_CPU_DIV,
    parameter int PAL_PPU_DIV  = DEF_PAL_PPU_DIV,
    parameter int RST_HOLD     = 8,
    parameter int CYC_W        = 32
) (
    input logic              sys_clock,
    input logic              reset,
    nes_clk_rst_gen_if.slave bus
);
    localparam int DIV_MAX = max_div(NTSC_CPU_DIV, NTSC_PPU_DIV, PAL_CPU_DIV, PAL_PPU_DIV);
    localparam int CNT_W   = (DIV_MAX > 2) ? $clog2(DIV_MAX) : 1;
    localparam int HOLD_W  = $clog2(RST_HOLD + 1);

    clk_state_t        state_q;
    clk_state_t        state_d;
    mode_t             mode_q;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic [HOLD_W-1:0] hold_cnt_d;
    logic [CYC_W-1:0]  cycles_q;
    logic [CYC_W-1:0]  cycles_d;
    logic [CNT_W-1:0]  cpu_last;
    logic [CNT_W-1:0]  ppu_last;
    logic              cnt_en;
    logic              cnt_clr;
    logic              cpu_tc;
    logic              ppu_tc;

    // Video standard is only taken while the system is held in reset.
    always_ff @(posedge sys_clock) begin
        if (reset) begin
            mode_q <= mode_t'(bus.pal_mode);
        end
    end

    assign cpu_last = (mode_q == PAL) ? CNT_W'(PAL_CPU_DIV - 1) : CNT_W'(NTSC_CPU_DIV - 1);
    assign ppu_last = (mode_q == PAL) ? CNT_W'(PAL_PPU_DIV - 1) : CNT_W'(NTSC_PPU_DIV - 1);

    // Counters run in every state except HALTED, and are zeroed on entry to HALTED
    // so that resume/step always start at a fresh CPU cycle with both phases aligned.
    assign cnt_en  = (state_q != HALTED);
    assign cnt_clr = (state_d == HALTED);

    nes_ce_div #(.W(CNT_W)) u_cpu_div (
        .clk_i  (sys_clock),
        .rst_i  (reset),
        .en_i   (cnt_en),
        .clr_i  (cnt_clr),
        .last_i (cpu_last),
        .tc_o   (cpu_tc)
    );

    nes_ce_div #(.W(CNT_W)) u_ppu_div (
        .clk_i  (sys_clock),
        .rst_i  (reset),
        .en_i   (cnt_en),
        .clr_i  (cnt_clr),
        .last_i (ppu_last),
        .tc_o   (ppu_tc)
    );

    // State, hold counter and CPU cycle counter registers.
    always_ff @(posedge sys_clock) begin
        if (reset) begin
            state_q    <= HOLD;
            hold_cnt_q <= '0;
            cycles_q   <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            cycles_q   <= cycles_d;
        end
    end

    // Next state: every transition out of HOLD/RUN/STEP happens on a CPU boundary.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        cycles_d   = cycles_q;
        unique case (state_q)
            HOLD: begin
                if (cpu_tc) begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    if (hold_cnt_q == HOLD_W'(RST_HOLD - 1)) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (cpu_tc) begin
                    cycles_d = cycles_q + CYC_W'(1);
                    if (bus.halt) begin
                        state_d = HALTED;
                    end
                end
            end
            HALTED: begin
                if (!bus.halt) begin
                    state_d = RUN;
                end else if (bus.step) begin
                    state_d = STEP;
                end
            end
            STEP: begin
                if (cpu_tc) begin
                    cycles_d = cycles_q + CYC_W'(1);
                    state_d  = bus.halt ? HALTED : RUN;
                end
            end
            default: state_d = HOLD;
        endcase
    end

    // Outputs decode the registered state and counters.
    always_comb begin
        bus.cpu_ce     = cpu_tc;
        bus.ppu_ce     = ppu_tc;
        bus.cpu_rst    = (state_q == HOLD);
        bus.ppu_rst    = (state_q == HOLD);
        bus.halted     = (state_q == HALTED);
        bus.cpu_cycles = cycles_q;
    end
endmodule

// File: tb/tb_nes_clk_rst_gen.sv
// Randomised + directed bench for nes_clk_rst_gen against a time-index reference model.
// Latency: outputs sampled on the falling edge, model advanced on the rising edge.
// Backpressure: n/a.
module tb_nes_clk_rst_gen;
    import nes_pkg::*;

    localparam int RST_HOLD = 8;
    localparam int CYC_W    = 32;
    localparam int PH_HOLD  = 0;
    localparam int PH_RUN   = 1;
    localparam int PH_HALT  = 2;
    localparam int PH_STEP  = 3;

    logic sys_clock = 1'b0;
    logic reset     = 1'b1;

    nes_clk_rst_gen_if #(.CYC_W(CYC_W)) bus ();

    nes_clk_rst_gen #(
        .RST_HOLD (RST_HOLD),
        .CYC_W    (CYC_W)
    ) dut (
        .sys_clock (sys_clock),
        .reset     (reset),
        .bus       (bus)
    );

    always #5 sys_clock = ~sys_clock;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: a running master-cycle index since the last (re)start of the
    // counters; enables fire when the index hits the last slot of each period.
    int               m_ph    = PH_HOLD;
    int               m_t     = 0;
    int               m_holds = 0;
    bit               m_pal   = 1'b0;
    bit               m_valid = 1'b0;
    logic [CYC_W-1:0] m_cyc   = '0;

    int ce_seen  = 0;
    int pce_seen = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int m_cdiv();
        return m_pal ? 16 : 12;
    endfunction

    function automatic int m_pdiv();
        return m_pal ? 5 : 4;
    endfunction

    function automatic bit m_cpu_ce();
        return (m_ph != PH_HALT) && ((m_t % m_cdiv()) == m_cdiv() - 1);
    endfunction

    function automatic bit m_ppu_ce();
        return (m_ph != PH_HALT) && ((m_t % m_pdiv()) == m_pdiv() - 1);
    endfunction

    task automatic model_step();
        bit ce;
        ce = m_cpu_ce();
        if (reset) begin
            m_pal   = bus.pal_mode;
            m_ph    = PH_HOLD;
            m_t     = 0;
            m_holds = 0;
            m_cyc   = '0;
            m_valid = 1'b1;
        end else begin
            case (m_ph)
                PH_HOLD: begin
                    if (ce) begin
                        m_holds++;
                        if (m_holds == RST_HOLD) m_ph = PH_RUN;
                    end
                    m_t++;
                end
                PH_RUN: begin
                    if (ce) m_cyc = m_cyc + 1;
                    if (ce && bus.halt) begin
                        m_ph = PH_HALT;
                        m_t  = 0;
                    end else begin
                        m_t++;
                    end
                end
                PH_HALT: begin
                    if (!bus.halt)     m_ph = PH_RUN;
                    else if (bus.step) m_ph = PH_STEP;
                end
                default: begin
                    if (ce) begin
                        m_cyc = m_cyc + 1;
                        if (bus.halt) begin
                            m_ph = PH_HALT;
                            m_t  = 0;
                        end else begin
                            m_ph = PH_RUN;
                            m_t++;
                        end
                    end else begin
                        m_t++;
                    end
                end
            endcase
        end
    endtask

    // Compare all outputs to the model, then advance one master cycle.
    task automatic tick();
        if (m_valid) begin
            chk("cpu_ce",     bus.cpu_ce,     m_cpu_ce());
            chk("ppu_ce",     bus.ppu_ce,     m_ppu_ce());
            chk("cpu_rst",    bus.cpu_rst,    m_ph == PH_HOLD);
            chk("ppu_rst",    bus.ppu_rst,    m_ph == PH_HOLD);
            chk("halted",     bus.halted,     m_ph == PH_HALT);
            chk("cpu_cycles", bus.cpu_cycles, m_cyc);
        end
        ce_seen  += (bus.cpu_ce === 1'b1) ? 1 : 0;
        pce_seen += (bus.ppu_ce === 1'b1) ? 1 : 0;
        @(posedge sys_clock);
        model_step();
        @(negedge sys_clock);
    endtask

    task automatic do_reset(input logic pal);
        reset        = 1'b1;
        bus.pal_mode = pal;
        repeat (3) tick();
        reset = 1'b0;
    endtask

    task automatic wait_ce(output int n);
        n = 0;
        while (bus.cpu_ce !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_rst_fall(output int n);
        n = 0;
        while (bus.cpu_rst !== 1'b0 && n < 400) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        bus.pal_mode = 1'b0;
        bus.halt     = 1'b0;
        bus.step     = 1'b0;

        // NTSC timing and reset values
        do_reset(1'b0);
        chk("rst_cpu_ce",  bus.cpu_ce,     0);
        chk("rst_ppu_ce",  bus.ppu_ce,     0);
        chk("rst_cpu_rst", bus.cpu_rst,    1);
        chk("rst_ppu_rst", bus.ppu_rst,    1);
        chk("rst_halted",  bus.halted,     0);
        chk("rst_cycles",  bus.cpu_cycles, 0);
        wait_rst_fall(n);
        chk("ntsc_rst_fall", n, 96);
        ce_seen = 0; pce_seen = 0;
        repeat (48) tick();
        chk("ntsc_cpu_ce_48", ce_seen, 4);
        chk("ntsc_ppu_ce_48", pce_seen, 12);

        // PAL latch, toggle after release is ignored
        do_reset(1'b1);
        bus.pal_mode = 1'b0;
        wait_rst_fall(n);
        chk("pal_rst_fall", n, 128);
        ce_seen = 0; pce_seen = 0;
        repeat (80) tick();
        chk("pal_cpu_ce_80", ce_seen, 5);
        chk("pal_ppu_ce_80", pce_seen, 16);

        // Halt mid-period
        do_reset(1'b0);
        wait_rst_fall(n);
        wait_ce(n);
        repeat (5) tick();
        bus.halt = 1'b1;
        wait_ce(n);
        chk("halt_last_ce", n, 7);
        tick();
        chk("halt_halted", bus.halted, 1);
        ce_seen = 0; pce_seen = 0;
        repeat (30) tick();
        chk("halt_no_cpu_ce", ce_seen, 0);
        chk("halt_no_ppu_ce", pce_seen, 0);
        chk("halt_cycles_frozen", bus.cpu_cycles, 2);

        // Single step, with a second step pulse inside the window
        bus.step = 1'b1;
        tick();
        bus.step = 1'b0;
        chk("step_running", bus.halted, 0);
        ce_seen = 0; pce_seen = 0;
        repeat (3) tick();
        bus.step = 1'b1;
        tick();
        bus.step = 1'b0;
        repeat (8) tick();
        chk("step_cpu_ce", ce_seen, 1);
        chk("step_ppu_ce", pce_seen, 3);
        chk("step_rehalted", bus.halted, 1);
        chk("step_cycles", bus.cpu_cycles, 3);
        ce_seen = 0;
        repeat (20) tick();
        chk("step_no_requeue", ce_seen, 0);

        // Resume wins over a simultaneous step
        bus.halt = 1'b0;
        bus.step = 1'b1;
        tick();
        bus.step = 1'b0;
        chk("resume_priority", bus.halted, 0);
        wait_ce(n);
        chk("resume_first_ce", n, 11);
        tick();
        wait_ce(n);
        chk("resume_period", n, 11);

        // Reset in the middle of a step
        bus.halt = 1'b1;
        wait_ce(n);
        tick();
        bus.step = 1'b1;
        tick();
        bus.step = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        chk("midstep_rst_cpu_rst", bus.cpu_rst,    1);
        chk("midstep_rst_halted",  bus.halted,     0);
        chk("midstep_rst_cycles",  bus.cpu_cycles, 0);
        chk("midstep_rst_cpu_ce",  bus.cpu_ce,     0);
        reset    = 1'b0;
        bus.halt = 1'b0;
        wait_rst_fall(n);
        chk("midstep_rehold", n, 96);
        chk("midstep_cycles_zero", bus.cpu_cycles, 0);

        // Random mix of mode, halt, step and reset
        for (int i = 0; i < 6000; i++) begin
            bus.pal_mode = 1'($urandom_range(0, 1));
            if (reset) begin
                if ($urandom_range(0, 2) == 0) reset = 1'b0;
            end else if ($urandom_range(0, 399) == 0) begin
                reset = 1'b1;
            end
            if ($urandom_range(0, 29) == 0) bus.halt = ~bus.halt;
            bus.step = !bus.step && ($urandom_range(0, 7) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
